// File: rtl/cpu_int_ctrl.sv
// Multi-source Z80 interrupt controller: synchronised request strobes, fixed-priority arbitration,
// pulse/level n_int per channel and an IM2 vector on INTACK; request to n_int low is 4 clkcpu edges.
module cpu_int_ctrl #(
  parameter int          NCH      = 4,
  parameter int          INT_LEN  = 32,
  parameter logic [7:0]  VEC_BASE = 8'hF0
) (
  input  logic           clkcpu,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] en,
  input  logic [NCH-1:0] level_mode,
  input  logic           m1,
  input  logic           iorq,
  output logic           n_int,
  output logic [7:0]     vector,
  output logic           vector_oe,
  output logic [NCH-1:0] pending,
  output logic [2:0]     active_ch
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(INT_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_ACK    = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] edge_q, edge_d;
  logic [NCH-1:0] pending_q, pending_d;
  state_t         state_q, state_d;
  logic [CHW-1:0] act_q, act_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           n_int_q, n_int_d;
  logic [7:0]     vector_q, vector_d;

  logic [NCH-1:0] rise;
  logic [NCH-1:0] req_mask;
  logic [NCH-1:0] act_onehot;
  logic [NCH-1:0] clr;
  logic [CHW-1:0] arb_ch;
  logic [7:0]     ch_field;
  logic           act_en;
  logic           act_lvl;
  logic           ack;

  always_comb begin
    sync1_d    = req;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    rise       = sync2_q & ~edge_q;
    ack        = m1 & iorq;
    act_onehot = (NCH)'(1) << act_q;
    act_en     = |(en & act_onehot);
    act_lvl    = |(level_mode & act_onehot);
    ch_field   = 8'({act_q, 1'b0});
    // Disabled channels are masked here so a bit being cleared this cycle is never granted.
    req_mask   = pending_q & en;

    arb_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_mask[i]) begin
        arb_ch = (CHW)'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    n_int_d  = n_int_q;
    vector_d = vector_q;
    clr      = '0;

    case (state_q)
      S_IDLE: begin
        if (|req_mask) begin
          act_d   = arb_ch;
          cnt_d   = '0;
          n_int_d = 1'b0;
          state_d = S_ASSERT;
        end
      end

      S_ASSERT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + (CW)'(1);
        end
        // Ack wins over disable and timeout; no pre-emption by higher-priority arrivals.
        if (ack) begin
          vector_d = VEC_BASE | ch_field;
          clr      = act_onehot;
          n_int_d  = 1'b1;
          state_d  = S_ACK;
        end else if (!act_en) begin
          n_int_d  = 1'b1;
          state_d  = S_GAP;
        end else if (!act_lvl && (cnt_q == (CW)'(INT_LEN - 1))) begin
          clr      = act_onehot;
          n_int_d  = 1'b1;
          state_d  = S_GAP;
        end
      end

      S_ACK: begin
        if (!ack) begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh edge on the clearing cycle keeps the request pending.
    pending_d = (pending_q & ~clr & en) | (rise & en);
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      state_q   <= S_IDLE;
      act_q     <= '0;
      cnt_q     <= '0;
      n_int_q   <= 1'b1;
      vector_q  <= VEC_BASE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      n_int_q   <= n_int_d;
      vector_q  <= vector_d;
    end
  end

  assign n_int     = n_int_q;
  assign vector    = vector_q;
  assign vector_oe = (state_q == S_ACK) && ack;
  assign pending   = pending_q;
  assign active_ch = 3'(act_q);

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Directed bench for cpu_int_ctrl: inputs change and outputs are sampled on the falling clkcpu edge.
module tb_cpu_int_ctrl;

  logic       clkcpu;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] en;
  logic [3:0] level_mode;
  logic       m1;
  logic       iorq;
  logic       n_int;
  logic [7:0] vector;
  logic       vector_oe;
  logic [3:0] pending;
  logic [2:0] active_ch;

  int checks = 0;
  int errors = 0;
  int len;

  cpu_int_ctrl #(
    .NCH      (4),
    .INT_LEN  (32),
    .VEC_BASE (8'hF0)
  ) dut (
    .clkcpu     (clkcpu),
    .rst_n      (rst_n),
    .req        (req),
    .en         (en),
    .level_mode (level_mode),
    .m1         (m1),
    .iorq       (iorq),
    .n_int      (n_int),
    .vector     (vector),
    .vector_oe  (vector_oe),
    .pending    (pending),
    .active_ch  (active_ch)
  );

  initial clkcpu = 1'b0;
  always #5 clkcpu = ~clkcpu;

  task automatic tick(input int n);
    repeat (n) @(negedge clkcpu);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = '0; en = 4'hF; level_mode = '0; m1 = 1'b0; iorq = 1'b0;
    tick(2);
    chk("rst_n_int",     32'(n_int),     32'h1);
    chk("rst_vector",    32'(vector),    32'hF0);
    chk("rst_vector_oe", 32'(vector_oe), 32'h0);
    chk("rst_pending",   32'(pending),   32'h0);
    chk("rst_active_ch", 32'(active_ch), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Pulse mode, no ack
    req = 4'b0001;
    tick(3);
    chk("t1_pending_lat", 32'(pending), 32'h1);
    chk("t1_n_int_lat",   32'(n_int),   32'h1);
    req = '0;
    tick(1);
    chk("t1_n_int_low",   32'(n_int),     32'h0);
    chk("t1_active_ch",   32'(active_ch), 32'h0);
    len = 0;
    while (n_int == 1'b0 && len < 100) begin
      len++;
      tick(1);
    end
    chk("t1_pulse_len",   32'(len),     32'd32);
    chk("t1_pending_end", 32'(pending), 32'h0);
    tick(3);
    chk("t1_no_retrig",   32'(n_int),   32'h1);

    // IM2 ack of channel 2
    req = 4'b0100;
    tick(3);
    req = '0;
    tick(1);
    chk("t2_n_int_low", 32'(n_int),     32'h0);
    chk("t2_active_ch", 32'(active_ch), 32'h2);
    tick(4);
    m1 = 1'b1; iorq = 1'b1;
    tick(1);
    chk("t2_vector",    32'(vector),    32'hF4);
    chk("t2_oe",        32'(vector_oe), 32'h1);
    chk("t2_n_int",     32'(n_int),     32'h1);
    chk("t2_pending",   32'(pending),   32'h0);
    tick(1);
    chk("t2_oe_hold",   32'(vector_oe), 32'h1);
    m1 = 1'b0; iorq = 1'b0;
    #1;
    chk("t2_oe_drop",   32'(vector_oe), 32'h0);
    tick(3);
    chk("t2_idle_n_int", 32'(n_int), 32'h1);

    // Priority: ch1 before ch3
    req = 4'b1010;
    tick(3);
    chk("t3_pending",   32'(pending), 32'hA);
    req = '0;
    tick(1);
    chk("t3_first_ch",  32'(active_ch), 32'h1);
    chk("t3_first_low", 32'(n_int),     32'h0);
    tick(2);
    m1 = 1'b1; iorq = 1'b1;
    tick(1);
    chk("t3_vec_f2",    32'(vector),  32'hF2);
    chk("t3_pend_left", 32'(pending), 32'h8);
    m1 = 1'b0; iorq = 1'b0;
    tick(1);
    chk("t3_gap_a",     32'(n_int), 32'h1);
    tick(1);
    chk("t3_gap_b",     32'(n_int), 32'h1);
    tick(1);
    chk("t3_second_low", 32'(n_int),     32'h0);
    chk("t3_second_ch",  32'(active_ch), 32'h3);
    m1 = 1'b1; iorq = 1'b1;
    tick(1);
    chk("t3_vec_f6",    32'(vector),  32'hF6);
    chk("t3_pend_none", 32'(pending), 32'h0);
    m1 = 1'b0; iorq = 1'b0;
    tick(3);

    // Level mode held, then disabled
    level_mode = 4'b0010;
    req = 4'b0010;
    tick(3);
    req = '0;
    tick(1);
    chk("t4_low",       32'(n_int),     32'h0);
    chk("t4_ch",        32'(active_ch), 32'h1);
    tick(500);
    chk("t4_still_low", 32'(n_int),   32'h0);
    chk("t4_pending",   32'(pending), 32'h2);
    en = 4'b1101;
    tick(1);
    chk("t4_dis_n_int", 32'(n_int),   32'h1);
    chk("t4_dis_pend",  32'(pending), 32'h0);
    tick(4);
    chk("t4_idle",      32'(n_int),   32'h1);
    en = 4'hF; level_mode = '0;
    tick(2);

    // Disabled channel ignores requests
    en = 4'b1110;
    req = 4'b0001;
    tick(3);
    chk("en_block_pend", 32'(pending), 32'h0);
    req = '0;
    tick(3);
    chk("en_block_int",  32'(n_int), 32'h1);
    en = 4'hF;
    tick(2);

    // New edge coincident with ack keeps the channel pending
    req = 4'b0001;
    tick(3);
    req = '0;
    tick(1);
    chk("t5_low", 32'(n_int), 32'h0);
    tick(2);
    req = 4'b0001;
    tick(2);
    m1 = 1'b1; iorq = 1'b1;
    tick(1);
    chk("t5_vec_f0",   32'(vector),    32'hF0);
    chk("t5_oe",       32'(vector_oe), 32'h1);
    chk("t5_pend_kept", 32'(pending),  32'h1);
    req = '0;
    m1 = 1'b0; iorq = 1'b0;
    tick(1);
    chk("t5_gap_a", 32'(n_int), 32'h1);
    tick(1);
    chk("t5_gap_b", 32'(n_int), 32'h1);
    tick(1);
    chk("t5_reissue",    32'(n_int),     32'h0);
    chk("t5_reissue_ch", 32'(active_ch), 32'h0);
    m1 = 1'b1; iorq = 1'b1;
    tick(1);
    chk("t5_cleared", 32'(pending), 32'h0);
    m1 = 1'b0; iorq = 1'b0;
    tick(3);

    // Reset during ASSERT
    req = 4'b1001;
    tick(3);
    req = '0;
    tick(1);
    chk("t6_low", 32'(n_int), 32'h0);
    tick(9);
    rst_n = 1'b0;
    #1;
    chk("t6_async_n_int", 32'(n_int),   32'h1);
    chk("t6_async_pend",  32'(pending), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t6_no_int",  32'(n_int),   32'h1);
    chk("t6_pend",    32'(pending), 32'h0);
    m1 = 1'b1; iorq = 1'b1;
    #1;
    chk("t6_no_oe",   32'(vector_oe), 32'h0);
    tick(1);
    chk("t6_no_oe_b", 32'(vector_oe), 32'h0);
    chk("t6_vector",  32'(vector),    32'hF0);
    m1 = 1'b0; iorq = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
